// File: rtl/fp32_div_sqrt_core_if.sv
// Divider handshake between the FP div/sqrt unit controller (master) and one core (slave).
interface fp32_div_sqrt_core_if;
  logic [31:0] input_lhs;
  logic [31:0] input_rhs;
  logic        input_is_divide;
  logic [2:0]  input_round_mode;
  logic        req;
  logic        finished;
  logic [31:0] result;
  logic [4:0]  fflags;

  modport master (
    output input_lhs, input_rhs, input_is_divide, input_round_mode, req,
    input  finished, result, fflags
  );

  modport slave (
    input  input_lhs, input_rhs, input_is_divide, input_round_mode, req,
    output finished, result, fflags
  );
endinterface

// File: rtl/fp32_div_sqrt_core.sv
// Iterative binary32 divide / square root (restoring, one bit per cycle) with RISC-V fflags.
// The square-root datapath is compiled in only when RSD_FP_SQRT_EN is defined.
module fp32_div_sqrt_core (
  input logic clk,
  input logic rst,
  fp32_div_sqrt_core_if.slave divBus
);
  localparam int ITER_BITS = 26;

  typedef enum logic [2:0] {IDLE, UNPACK, ITERATE, ROUND, DONE} stateT;
  stateT state_q, state_d;

  logic [31:0] lhs_q, rhs_q, result_q;
  logic        isDiv_q, sign_q;
  logic [2:0]  rm_q;
  logic [4:0]  cnt_q, fflags_q;
  logic signed [10:0] exp_q;
  logic [29:0] rem_q;
  logic [23:0] divisor_q;
  logic [25:0] quot_q;
`ifdef RSD_FP_SQRT_EN
  logic [51:0] rad_q;
`endif

  // Subnormals are normalized so every significand enters the iteration with its MSB set.
  function automatic logic [34:0] unpackOp(input logic [31:0] x);
    logic [23:0] m;
    logic [4:0]  lz;
    logic signed [10:0] e;
    m  = {(x[30:23] != 8'd0), x[22:0]};
    lz = 5'd0;
    for (int i = 0; i < 24; i++) if (m[i]) lz = 5'(23 - i);
    e = (x[30:23] == 8'd0) ? 11'sd1 - 11'(lz) : 11'({3'b000, x[30:23]});
    return {e, m << lz};
  endfunction

  function automatic logic roundUp(input logic [2:0] rm, input logic sign, input logic lsb,
                                   input logic g, input logic rest);
    case (rm)
      3'd1:    roundUp = 1'b0;
      3'd2:    roundUp = sign && (g || rest);
      3'd3:    roundUp = !sign && (g || rest);
      3'd4:    roundUp = g;
      default: roundUp = g && (rest || lsb);
    endcase
  endfunction

  logic aSign, bSign, aNan, bNan, aSnan, bSnan, aInf, bInf, aZero, bZero, divSign;
  assign aSign   = lhs_q[31];
  assign bSign   = rhs_q[31];
  assign aNan    = (lhs_q[30:23] == 8'hFF) && (lhs_q[22:0] != 23'd0);
  assign bNan    = (rhs_q[30:23] == 8'hFF) && (rhs_q[22:0] != 23'd0);
  assign aSnan   = aNan && !lhs_q[22];
  assign bSnan   = bNan && !rhs_q[22];
  assign aInf    = (lhs_q[30:0] == 31'h7F800000);
  assign bInf    = (rhs_q[30:0] == 31'h7F800000);
  assign aZero   = (lhs_q[30:0] == 31'd0);
  assign bZero   = (rhs_q[30:0] == 31'd0);
  assign divSign = aSign ^ bSign;

  logic        isSpecial;
  logic [31:0] specResult;
  logic [4:0]  specFlags;
  always_comb begin
    isSpecial  = 1'b1;
    specResult = 32'h7FC00000;
    specFlags  = 5'b00000;
    if (isDiv_q) begin
      if (aNan || bNan) specFlags = {(aSnan || bSnan), 4'b0000};
      else if ((aZero && bZero) || (aInf && bInf)) specFlags = 5'b10000;
      else if (aInf) specResult = {divSign, 8'hFF, 23'd0};
      else if (bZero) begin
        specResult = {divSign, 8'hFF, 23'd0};
        specFlags  = 5'b01000;
      end
      else if (bInf || aZero) specResult = {divSign, 31'd0};
      else isSpecial = 1'b0;
    end else begin
`ifdef RSD_FP_SQRT_EN
      if (aNan) specFlags = {aSnan, 4'b0000};
      else if (aZero) specResult = lhs_q;
      else if (aSign) specFlags = 5'b10000;
      else if (aInf) specResult = lhs_q;
      else isSpecial = 1'b0;
`else
      specFlags = 5'b10000;
`endif
    end
  end

  logic signed [10:0] aExp, bExp, divExp;
  logic [23:0] aMant, bMant;
  logic        mantLt;
  assign {aExp, aMant} = unpackOp(lhs_q);
  assign {bExp, bMant} = unpackOp(rhs_q);
  // A smaller dividend significand is pre-doubled so the first quotient bit is always 1.
  assign mantLt = (aMant < bMant);
  assign divExp = aExp - bExp + 11'sd127 - {10'd0, mantLt};

`ifdef RSD_FP_SQRT_EN
  logic signed [10:0] sqrtUnb, sqrtEven, sqrtExp;
  logic        sqrtOdd;
  logic [24:0] sqrtMant;
  assign sqrtUnb  = aExp - 11'sd127;
  assign sqrtOdd  = sqrtUnb[0];
  assign sqrtEven = sqrtUnb - {10'd0, sqrtOdd};
  assign sqrtExp  = (sqrtEven >>> 1) + 11'sd127;
  assign sqrtMant = sqrtOdd ? {aMant, 1'b0} : {1'b0, aMant};
`endif

  logic [29:0] remShift, trial, remNext;
  logic [30:0] diff;
  logic        bitOk;
  always_comb begin
    remShift = rem_q;
    trial    = {6'd0, divisor_q};
`ifdef RSD_FP_SQRT_EN
    if (!isDiv_q) begin
      remShift = {rem_q[27:0], rad_q[51:50]};
      trial    = {2'b00, quot_q, 2'b01};
    end
`endif
    diff    = {1'b0, remShift} - {1'b0, trial};
    bitOk   = !diff[30];
    remNext = bitOk ? diff[29:0] : remShift;
  end

  logic        denorm, remSticky, stickyAll, guardBit, roundBit, up, fullUp;
  logic        overflow, inexact, tiny, ovfInf;
  logic signed [10:0] shRaw;
  logic [4:0]  shAmt;
  logic [51:0] shifted;
  logic [24:0] mantRnd;
  logic [10:0] expBase;
  logic [33:0] sum;
  logic [31:0] rndResult;
  logic [4:0]  rndFlags;
  // Tininess uses the unbounded-exponent rounding, hence the second roundUp on the unshifted quotient.
  always_comb begin
    denorm    = (exp_q <= 11'sd0);
    shRaw     = 11'sd1 - exp_q;
    shAmt     = 5'd0;
    if (denorm) shAmt = (shRaw > 11'sd26) ? 5'd26 : shRaw[4:0];
    shifted   = {quot_q, 26'd0} >> shAmt;
    remSticky = (rem_q != 30'd0);
    stickyAll = remSticky || (shifted[25:0] != 26'd0);
    guardBit  = shifted[27];
    roundBit  = shifted[26];
    up        = roundUp(rm_q, sign_q, shifted[28], guardBit, roundBit || stickyAll);
    mantRnd   = {1'b0, shifted[51:28]} + {24'd0, up};
    expBase   = denorm ? 11'd0 : exp_q - 11'sd1;
    sum       = {expBase, 23'd0} + {9'd0, mantRnd};
    overflow  = (sum[33:23] >= 11'd255);
    inexact   = guardBit || roundBit || stickyAll;
    fullUp    = roundUp(rm_q, sign_q, quot_q[2], quot_q[1], quot_q[0] || remSticky);
    tiny      = denorm && !((exp_q == 11'sd0) && (&quot_q[25:2]) && fullUp);
    ovfInf    = (rm_q == 3'd0) || (rm_q == 3'd4) || ((rm_q == 3'd3) && !sign_q)
             || ((rm_q == 3'd2) && sign_q);
    if (overflow) rndResult = ovfInf ? {sign_q, 8'hFF, 23'd0} : {sign_q, 31'h7F7FFFFF};
    else          rndResult = {sign_q, sum[30:0]};
    rndFlags  = {2'b00, overflow, tiny && inexact && !overflow, inexact || overflow};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (divBus.req) state_d = UNPACK;
      UNPACK:  state_d = isSpecial ? DONE : ITERATE;
      ITERATE: if (cnt_q == 5'(ITER_BITS - 1)) state_d = ROUND;
      ROUND:   state_d = DONE;
      DONE:    if (divBus.req) state_d = UNPACK;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    divBus.finished = (state_q == DONE);
    divBus.result   = result_q;
    divBus.fflags   = fflags_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lhs_q     <= 32'd0;
      rhs_q     <= 32'd0;
      isDiv_q   <= 1'b0;
      rm_q      <= 3'd0;
      sign_q    <= 1'b0;
      exp_q     <= 11'sd0;
      rem_q     <= 30'd0;
      divisor_q <= 24'd0;
      quot_q    <= 26'd0;
      cnt_q     <= 5'd0;
      result_q  <= 32'd0;
      fflags_q  <= 5'd0;
`ifdef RSD_FP_SQRT_EN
      rad_q     <= 52'd0;
`endif
    end else begin
      if (divBus.req && (state_q == IDLE || state_q == DONE)) begin
        lhs_q   <= divBus.input_lhs;
        rhs_q   <= divBus.input_rhs;
        isDiv_q <= divBus.input_is_divide;
        rm_q    <= (divBus.input_round_mode > 3'd4) ? 3'd0 : divBus.input_round_mode;
      end
      case (state_q)
        UNPACK: begin
          cnt_q  <= 5'd0;
          quot_q <= 26'd0;
          if (isSpecial) begin
            result_q <= specResult;
            fflags_q <= specFlags;
          end else if (isDiv_q) begin
            sign_q    <= divSign;
            exp_q     <= divExp;
            rem_q     <= mantLt ? {5'd0, aMant, 1'b0} : {6'd0, aMant};
            divisor_q <= bMant;
          end
`ifdef RSD_FP_SQRT_EN
          else begin
            sign_q <= 1'b0;
            exp_q  <= sqrtExp;
            rem_q  <= 30'd0;
            rad_q  <= {sqrtMant, 27'd0};
          end
`endif
        end
        ITERATE: begin
          cnt_q  <= cnt_q + 5'd1;
          quot_q <= {quot_q[24:0], bitOk};
          rem_q  <= isDiv_q ? {remNext[28:0], 1'b0} : remNext;
`ifdef RSD_FP_SQRT_EN
          rad_q  <= {rad_q[49:0], 2'b00};
`endif
        end
        ROUND: begin
          result_q <= rndResult;
          fflags_q <= rndFlags;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/fp32_div_sqrt_core.md
# fp32_div_sqrt_core

Iterative IEEE-754 binary32 divide/square-root datapath: the responder side of the divider handshake driven by the FP div/sqrt unit controller. It accepts one operation per `req`, computes a correctly rounded result with RISC-V accrued-exception flags, and holds result and `finished` until the next request. Each FP div/sqrt issue lane instantiates one core; the controller's flush logic drives `rst`.

## Interface
- `ITER_BITS`, 26: quotient/root bits produced, one per iteration (24 significand + guard + round; sticky comes from the final remainder). Fixed; not meant to be overridden.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-high; also pulsed by the controller on flush.
- `input_lhs`  in  32  dividend, or radicand for sqrt.
- `input_rhs`  in  32  divisor; ignored for sqrt.
- `input_is_divide`  in  1  1 = lhs/rhs, 0 = sqrt(lhs).
- `input_round_mode`  in  3  RISC-V rm: 0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM; 5–7 are treated as RNE.
- `req`  in  1  start request; inputs are sampled in the same cycle.
- `finished`  out  1  result valid; level signal.
- `result`  out  32  binary32 result.
- `fflags`  out  5  {NV, DZ, OF, UF, NX}.

## Operation
- FSM states:
  - IDLE: `req` latches all inputs and goes to UNPACK.
  - UNPACK: classify operands.
    - Special case → DONE.
    - Otherwise normalize subnormals with a leading-zero count, then go to ITERATE.
    - Div exponent = ea − eb + 127. Sqrt makes the exponent even and halves it; the odd-exponent significand is shifted left by 1.
  - ITERATE: 26 cycles of radix-2 restoring division or digit-by-digit root. Counter runs 0..25. `req` is ignored.
  - ROUND:
    - sticky = remainder ≠ 0.
    - If the biased exponent is ≤ 0, denormalize by right shift; bits shifted out go into sticky.
    - Round per rm, renormalize on carry-out, then detect overflow.
  - DONE: `finished`=1; `result`/`fflags` stable. `req` here latches a new op and goes to UNPACK, deasserting `finished` next cycle.
- Special cases:
  - Any NaN operand → 0x7FC00000 (canonical). NV is set if any operand is sNaN.
  - 0/0, ∞/∞ → NaN, NV. Finite nonzero/0 → ±∞, DZ. x/∞ → ±0. ∞/finite → ±∞. 0/finite nonzero → ±0.
  - sqrt: −0 → −0; +∞ → +∞; negative nonzero (incl. −∞) → NaN, NV; +0 → +0.
  - Result sign for div is the XOR of the operand signs.
- Flags:
  - NX when guard|round|sticky ≠ 0.
  - OF: result is ±∞ for RNE/RMM and for the rounding direction away from zero; otherwise max finite (0x7F7FFFFF with sign). OF always sets NX.
  - UF: tininess detected after rounding, raised only together with NX.
  - Special cases never set NX.

## Timing
- Reset: state IDLE, `finished`=0, `result`=0x00000000, `fflags`=0, counter 0. Asynchronous; mid-operation reset aborts with no output.
- Let `req` be in cycle 0:
  - Normal operand path: `finished` rises in cycle 29 (UNPACK 1, ITERATE 26, ROUND 1, DONE entry).
  - Special-case path: `finished` rises in cycle 2.
- `finished` and outputs hold indefinitely in DONE until `req` or `rst`.
- `req` in UNPACK/ITERATE/ROUND is dropped with no effect. The controller guarantees it only requests from RESERVED.
- `req` and `rst` in the same cycle: reset wins.

## Configuration
- `RSD_FP_SQRT_EN` defined: sqrt path compiled in as above.
- `RSD_FP_SQRT_EN` undefined:
  - Root iteration logic is removed.
  - Any request with `input_is_divide`=0 returns 0x7FC00000 with NV on the special-case timing (`finished` at cycle 2).
  - Divide behaviour is unchanged.

## Test plan
- 0x40C00000 / 0x40400000 (6/3), RNE → 0x40000000, fflags 0, `finished` first high exactly 29 cycles after `req`.
- 0x3F800000 / 0x40400000 (1/3): RNE → 0x3EAAAAAB, NX (0x01); RTZ → 0x3EAAAAAA, NX.
- sqrt 0x40000000, RNE → 0x3FB504F3, NX. sqrt 0x40800000 → 0x40000000, fflags 0.
- 0x3F800000 / 0x00000000 → 0x7F800000, DZ (0x08), `finished` at cycle 2. sqrt 0xBF800000 → 0x7FC00000, NV (0x10).
- 0x7F7FFFFF / 0x3F000000: RNE → 0x7F800000, fflags 0x05 (OF|NX); RTZ → 0x7F7FFFFF, fflags 0x05.
- Assert `rst` at cycle 10 of a divide → `finished`=0 and `result`=0 immediately. New `req` afterwards → correct result at +29, with no leftover state from the aborted operation.
